// File: rtl/acia_rx_fifo.sv
// ACIA async serial receiver with input deglitch filter, run-time frame format,
// break detection and a show-ahead RX FIFO carrying per-byte {brk, perr, ferr}.
module acia_rx_fifo #(
    parameter int DIVW = 16,
    parameter int FILT = 8,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_serial,
    input  logic [DIVW-1:0] baud_div,
    input  logic [1:0]      data_bits,
    input  logic [1:0]      parity_mode,
    input  logic            stop2,
    output logic [7:0]      rx_data,
    output logic [2:0]      rx_status,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [AW:0]     rx_count,
    output logic            rx_overrun,
    input  logic            clr_overrun,
    output logic            rx_busy
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

    typedef struct packed {
        logic       brk;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } entry_t;

    // Deglitch: the filtered line only moves once every stage agrees.
    logic [FILT-1:0] filt_pipe;
    logic            line;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_pipe <= '1;
            line      <= 1'b1;
        end else begin
            filt_pipe <= {filt_pipe[FILT-2:0], rx_serial};
            if (&filt_pipe)
                line <= 1'b1;
            else if (~|filt_pipe)
                line <= 1'b0;
        end
    end

    state_t          state;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_l;
    logic [2:0]      last_l;
    logic [1:0]      par_l;
    logic            stop2_l;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            zero;
    logic            perr;
    logic            ferr;

    logic   tick;
    logic   par_en;
    logic   par_odd;
    logic   push;
    entry_t push_e;

    assign tick    = (cnt == '0);
    assign par_en  = (par_l == 2'b01) || (par_l == 2'b10);
    assign par_odd = (par_l == 2'b10);

    always_comb begin
        push   = 1'b0;
        push_e = '0;
        if (tick) begin
            case (state)
                STOP1: begin
                    if (!line && zero) begin
                        push   = 1'b1;
                        push_e = '{brk: 1'b1, perr: perr, ferr: 1'b1, data: 8'h00};
                    end else if (!stop2_l) begin
                        push   = 1'b1;
                        push_e = '{brk: 1'b0, perr: perr, ferr: ~line, data: shreg};
                    end
                end
                STOP2: begin
                    push   = 1'b1;
                    push_e = '{brk: 1'b0, perr: perr, ferr: ferr | ~line, data: shreg};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_l   <= '0;
            last_l  <= '0;
            par_l   <= '0;
            stop2_l <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            zero    <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Frame format is frozen here so mid-frame edits hit only the next frame.
                    if (!line) begin
                        cnt     <= baud_div >> 1;
                        div_l   <= baud_div;
                        last_l  <= 3'd4 + {1'b0, data_bits};
                        par_l   <= parity_mode;
                        stop2_l <= stop2;
                        state   <= START;
                    end
                end
                BRKWAIT: begin
                    if (line)
                        state <= IDLE;
                end
                default: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt <= div_l;
                        case (state)
                            START: begin
                                if (line) begin
                                    state <= IDLE;
                                end else begin
                                    state   <= DATA;
                                    bit_idx <= '0;
                                    shreg   <= '0;
                                    zero    <= 1'b1;
                                    perr    <= 1'b0;
                                    ferr    <= 1'b0;
                                end
                            end
                            DATA: begin
                                shreg[bit_idx] <= line;
                                zero           <= zero & ~line;
                                if (bit_idx == last_l)
                                    state <= par_en ? PARITY : STOP1;
                                else
                                    bit_idx <= bit_idx + 1'b1;
                            end
                            PARITY: begin
                                perr  <= ((^shreg) ^ line) != par_odd;
                                zero  <= zero & ~line;
                                state <= STOP1;
                            end
                            STOP1: begin
                                if (!line && zero) begin
                                    state <= BRKWAIT;
                                end else begin
                                    ferr  <= ~line;
                                    state <= stop2_l ? STOP2 : IDLE;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

    entry_t          mem [1 << AW];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            overrun;
    logic            full;
    logic            pop;
    logic            write;
    entry_t          head;

    assign full  = (count == DEPTH);
    assign pop   = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    assign write = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (write)
            mem[wr_ptr] <= push_e;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (write)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_count   = count;
    assign rx_overrun = overrun;
    assign rx_data    = rx_valid ? head.data : 8'h00;
    assign rx_status  = rx_valid ? {head.brk, head.perr, head.ferr} : 3'b000;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo: frame formats, parity/framing errors, break,
// FIFO overrun, deglitch and false start, with a depth-4 FIFO.
module tb_acia_rx_fifo;

    localparam int AW  = 2;
    localparam int BIT = 139;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_serial = 1'b1;
    logic [15:0]   baud_div = 16'd138;
    logic [1:0]    data_bits = 2'b11;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop2 = 1'b0;
    logic [7:0]    rx_data;
    logic [2:0]    rx_status;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [AW:0]   rx_count;
    logic          rx_overrun;
    logic          clr_overrun = 1'b0;
    logic          rx_busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    acia_rx_fifo #(.DIVW(16), .FILT(8), .AW(AW)) dut (
        .clk(clk), .reset(reset), .rx_serial(rx_serial), .baud_div(baud_div),
        .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
        .rx_data(rx_data), .rx_status(rx_status), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .rx_overrun(rx_overrun),
        .clr_overrun(clr_overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic b, input int n);
        rx_serial = b;
        cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                              input logic pbit, input int nstop);
        drive(1'b0, BIT);
        for (int i = 0; i < nb; i++) drive(d[i], BIT);
        if (has_par) drive(pbit, BIT);
        for (int i = 0; i < nstop; i++) drive(1'b1, BIT);
        drive(1'b1, 2 * BIT);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic [2:0] s);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, d);
        chk({tag, "_status"}, rx_status, s);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;

        cyc(5);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_status", rx_status, 0);
        reset = 1'b0;
        cyc(20);

        // 8N1 0xA5 with push-timing window around the stop-bit sample.
        b = 8'hA5;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(1'b1, 30);
        chk("a5_count_before", rx_count, 0);
        chk("a5_busy", rx_busy, 1);
        drive(1'b1, 80);
        chk("a5_count_after", rx_count, 1);
        drive(1'b1, 2 * BIT);
        chk("a5_idle", rx_busy, 0);
        pop_chk("a5", 8'hA5, 3'b000);
        chk("a5_empty", rx_valid, 0);

        // 7E1: wrong then right parity bit for 0x41.
        data_bits   = 2'b10;
        parity_mode = 2'b01;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1);
        chk("7e1_count", rx_count, 2);
        pop_chk("7e1_bad", 8'h41, 3'b010);
        pop_chk("7e1_good", 8'h41, 3'b000);

        // 7O1 with the correct odd parity bit.
        parity_mode = 2'b10;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1);
        pop_chk("7o1", 8'h41, 3'b000);

        // 8N2, second stop bit low (kept short so the trailing low is a false start).
        data_bits   = 2'b11;
        parity_mode = 2'b00;
        stop2       = 1'b1;
        b = 8'h3C;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(1'b1, BIT);
        drive(1'b0, 100);
        drive(1'b1, 3 * BIT);
        chk("8n2_count", rx_count, 1);
        chk("8n2_busy", rx_busy, 0);
        pop_chk("8n2", 8'h3C, 3'b001);
        stop2 = 1'b0;

        // 5N1 at the narrowest width; upper bits must read 0.
        data_bits = 2'b00;
        send_frame(8'hFF, 5, 1'b0, 1'b0, 1);
        pop_chk("5n1", 8'h1F, 3'b000);
        data_bits = 2'b11;

        // Config edited mid-frame must not affect the frame in flight.
        b = 8'h5A;
        rx_serial = 1'b0;
        cyc(BIT / 2);
        data_bits   = 2'b00;
        parity_mode = 2'b01;
        cyc(BIT - BIT / 2);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(1'b1, 3 * BIT);
        pop_chk("midcfg", 8'h5A, 3'b000);
        data_bits   = 2'b11;
        parity_mode = 2'b00;

        // Break: line low 12 bit times.
        drive(1'b0, 12 * BIT);
        chk("brk_count_low", rx_count, 1);
        chk("brk_busy_low", rx_busy, 1);
        drive(1'b1, 3 * BIT);
        chk("brk_count_high", rx_count, 1);
        chk("brk_busy_high", rx_busy, 0);
        pop_chk("brk", 8'h00, 3'b101);

        // Overrun: 5 bytes into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i * 8'h11);
            send_frame(b, 8, 1'b0, 1'b0, 1);
        end
        chk("ovr_count", rx_count, 4);
        chk("ovr_flag", rx_overrun, 1);
        pop_chk("ovr0", 8'h11, 3'b000);
        pop_chk("ovr1", 8'h22, 3'b000);
        pop_chk("ovr2", 8'h33, 3'b000);
        pop_chk("ovr3", 8'h44, 3'b000);
        chk("ovr_empty", rx_valid, 0);
        chk("ovr_sticky", rx_overrun, 1);
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared", rx_overrun, 0);

        // Pop on empty is ignored.
        rx_ready = 1'b1;
        cyc(3);
        rx_ready = 1'b0;
        chk("empty_pop_count", rx_count, 0);

        // Short glitch is filtered out entirely.
        drive(1'b0, 5);
        drive(1'b1, 50);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_count", rx_count, 0);

        // 0.3-bit low pulse: start detected then rejected at mid-bit.
        drive(1'b0, 42);
        chk("fstart_busy", rx_busy, 1);
        drive(1'b1, BIT);
        chk("fstart_idle", rx_busy, 0);
        chk("fstart_count", rx_count, 0);

        // Reset mid-frame aborts without a push.
        drive(1'b0, 3 * BIT);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        drive(1'b1, 3 * BIT);
        chk("rstmid_count", rx_count, 0);
        chk("rstmid_busy", rx_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
